// File: rtl/phys_reg_allocator_if.sv
// rtl/phys_reg_allocator_if.sv - rename/commit side signals of the physical register allocator
//
// Purpose: bundles the allocation handshake (rename side) and the release
// path (commit side) of the physical-register free list.
// Signals:
//   alloc_req[1:0]  rename slots needing a destination tag
//   alloc_gnt[1:0]  slots granted this cycle
//   alloc_tag0/1    granted tags (0 when the slot is not granted)
//   rename_stall    requests not satisfiable, rename holds both slots
//   free_vld[1:0]   commit returns free_tag0/free_tag1
//   free_tag0/1     released tags
//   free_count      entries currently in the free list
//   overflow_err    sticky: a free was dropped because the list was full
// Modports: slave = allocator, master = rename/commit driver.
interface phys_reg_allocator_if #(
  parameter int TAG_W = 6,
  parameter int CNT_W = 6
);
  logic [1:0]       alloc_req;
  logic [1:0]       alloc_gnt;
  logic [TAG_W-1:0] alloc_tag0;
  logic [TAG_W-1:0] alloc_tag1;
  logic             rename_stall;
  logic [1:0]       free_vld;
  logic [TAG_W-1:0] free_tag0;
  logic [TAG_W-1:0] free_tag1;
  logic [CNT_W-1:0] free_count;
  logic             overflow_err;

  modport slave (
    input  alloc_req, free_vld, free_tag0, free_tag1,
    output alloc_gnt, alloc_tag0, alloc_tag1, rename_stall, free_count, overflow_err
  );

  modport master (
    output alloc_req, free_vld, free_tag0, free_tag1,
    input  alloc_gnt, alloc_tag0, alloc_tag1, rename_stall, free_count, overflow_err
  );
endinterface

// File: rtl/phys_reg_allocator.sv
// rtl/phys_reg_allocator.sv - dual-slot physical register free list for rename
//
// Purpose: circular free list of FL_DEPTH physical tags. Hands out up to two
// destination tags per cycle (all-or-nothing) and reclaims up to two released
// tags per cycle from commit.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (refills list with NUM_AREGS..NUM_PREGS-1)
//   bus   phys_reg_allocator_if.slave: alloc_req/gnt/tag0/tag1/rename_stall,
//         free_vld/free_tag0/free_tag1, free_count, overflow_err
module phys_reg_allocator #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int TAG_W     = 6,
  parameter int FL_DEPTH  = NUM_PREGS - NUM_AREGS
) (
  input logic clk,
  input logic rst,
  phys_reg_allocator_if.slave bus
);
  localparam int PTR_W = $clog2(FL_DEPTH);
  localparam int CNT_W = $clog2(FL_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FL_DEPTH);

  logic [TAG_W-1:0] fl [FL_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             overflow_q;

  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [1:0]       n_req, n_gnt, n_acc;
  logic             grant_ok;
  logic [1:0]       gnt;
  logic [TAG_W-1:0] tag0, tag1;
  logic             acc0, acc1, drop;

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);

  always_comb begin
    n_req    = {1'b0, bus.alloc_req[0]} + {1'b0, bus.alloc_req[1]};
    // All-or-nothing keeps the two rename slots in program order.
    grant_ok = (count >= CNT_W'(n_req));
    gnt      = grant_ok ? bus.alloc_req : 2'b00;
    n_gnt    = grant_ok ? n_req : 2'd0;
    tag0     = '0;
    tag1     = '0;
    if (gnt[0]) tag0 = fl[head];
    // Slot 1 takes the next entry only when slot 0 consumed the head.
    if (gnt[1]) tag1 = gnt[0] ? fl[head_p1] : fl[head];

    // Fullness is judged on the pre-allocation count; port 1 also sees
    // the slot port 0 may have just filled.
    acc0  = bus.free_vld[0] && (count < FULL);
    acc1  = bus.free_vld[1] && ((count + CNT_W'(acc0)) < FULL);
    drop  = (bus.free_vld[0] && !acc0) || (bus.free_vld[1] && !acc1);
    n_acc = {1'b0, acc0} + {1'b0, acc1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FL_DEPTH; k++) begin
        fl[k] <= TAG_W'(NUM_AREGS + k);
      end
      head       <= '0;
      tail       <= '0;
      count      <= FULL;
      overflow_q <= 1'b0;
    end else begin
      if (acc0) fl[tail] <= bus.free_tag0;
      if (acc1) fl[acc0 ? tail_p1 : tail] <= bus.free_tag1;
      head  <= head + PTR_W'(n_gnt);
      tail  <= tail + PTR_W'(n_acc);
      count <= count - CNT_W'(n_gnt) + CNT_W'(n_acc);
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign bus.alloc_gnt    = gnt;
  assign bus.alloc_tag0   = tag0;
  assign bus.alloc_tag1   = tag1;
  assign bus.rename_stall = !grant_ok;
  assign bus.free_count   = count;
  assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_phys_reg_allocator.sv
// tb/tb_phys_reg_allocator.sv - scoreboard bench for phys_reg_allocator
module tb_phys_reg_allocator;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  phys_reg_allocator_if bus ();

  phys_reg_allocator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] gnt;
    logic [5:0] t0;
    logic [5:0] t1;
    logic       stall;
    logic [5:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   fl_q[$];
  bit   ovf_m;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   stim_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  function automatic void model_reset();
    fl_q.delete();
    for (int k = 32; k < 64; k++) fl_q.push_back(k);
    ovf_m = 1'b0;
  endfunction

  // Drive one cycle of stimulus, push the expected response, advance the model.
  task automatic drive(input logic [1:0] req, input logic [1:0] fv,
                       input logic [5:0] ft0, input logic [5:0] ft1, input logic r);
    exp_t e;
    int   n, c0, acc, ng;
    @(negedge clk);
    rst           = r;
    bus.alloc_req = req;
    bus.free_vld  = fv;
    bus.free_tag0 = ft0;
    bus.free_tag1 = ft1;
    n  = int'(req[0]) + int'(req[1]);
    c0 = fl_q.size();
    e.gnt   = (c0 >= n) ? req : 2'b00;
    e.stall = (c0 < n);
    e.t0    = '0;
    e.t1    = '0;
    case (e.gnt)
      2'b11: begin e.t0 = 6'(fl_q[0]); e.t1 = 6'(fl_q[1]); end
      2'b01: e.t0 = 6'(fl_q[0]);
      2'b10: e.t1 = 6'(fl_q[0]);
      default: ;
    endcase
    e.cnt = 6'(c0);
    e.ovf = ovf_m;
    exp_q.push_back(e);
    if (r) begin
      model_reset();
    end else begin
      ng = int'(e.gnt[0]) + int'(e.gnt[1]);
      repeat (ng) void'(fl_q.pop_front());
      acc = 0;
      if (fv[0]) begin
        if (c0 + acc < 32) begin fl_q.push_back(int'(ft0)); acc++; end
        else ovf_m = 1'b1;
      end
      if (fv[1]) begin
        if (c0 + acc < 32) begin fl_q.push_back(int'(ft1)); acc++; end
        else ovf_m = 1'b1;
      end
    end
  endtask

  task automatic alloc_n(input int n);
    repeat (n / 2) drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    if (n % 2 == 1) drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
  endtask

  task automatic free_n(input int n);
    repeat (n / 2) drive(2'b00, 2'b11, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'b0);
    if (n % 2 == 1) drive(2'b00, 2'b01, 6'($urandom_range(0, 63)), 6'd0, 1'b0);
  endtask

  // Monitor: compares DUT outputs against the scoreboard each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("alloc_gnt",    32'(bus.alloc_gnt),    32'(e.gnt));
        chk("alloc_tag0",   32'(bus.alloc_tag0),   32'(e.t0));
        chk("alloc_tag1",   32'(bus.alloc_tag1),   32'(e.t1));
        chk("rename_stall", 32'(bus.rename_stall), 32'(e.stall));
        chk("free_count",   32'(bus.free_count),   32'(e.cnt));
        chk("overflow_err", 32'(bus.overflow_err), 32'(e.ovf));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    bus.alloc_req = '0;
    bus.free_vld  = '0;
    bus.free_tag0 = '0;
    bus.free_tag1 = '0;
    repeat (2) @(negedge clk);
    model_reset();

    // Reset state and first dual grant.
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    alloc_n(30);
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);

    // count = 1 with tag 63 at head.
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b1);
    alloc_n(31);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    drive(2'b10, 2'b00, 6'd0, 6'd0, 1'b0);

    // Empty list: frees are not bypassed to a same-cycle request.
    drive(2'b01, 2'b11, 6'd5, 6'd9, 1'b0);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);

    // Pointer wrap across index 31.
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b1);
    alloc_n(31);
    free_n(31);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);

    // Overflow on a full list, sticky until reset.
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b1);
    drive(2'b00, 2'b01, 6'd7, 6'd0, 1'b0);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    drive(2'b01, 2'b11, 6'd3, 6'd4, 1'b1);
    drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 2000; i++) begin
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
            ($urandom_range(0, 199) == 0));
    end
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    stim_done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
